// File: rtl/osmlgd_frame_sched.sv
// Frame scheduler in front of the osmlgd_top decoder: FIFO-buffers codewords, issues one at a
// time, tags each result and presents it on a valid/ready port, with a watchdog passthrough.
module osmlgd_frame_sched #(
    parameter int W       = 256,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             dec_work,
    output logic [W-1:0]     dec_tx,
    input  logic             dec_free,
    input  logic [W-1:0]     dec_deout,
    input  logic             dec_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic             err_spurious,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends combinationally on ready, and valid/data hold until the transfer.

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];
    logic [W-1:0]       dec_tx_q, dec_tx_d;
    logic               dec_work_q, dec_work_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_timeout_q, out_timeout_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [PW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Count is derived from the wrap-bit pointers, so full and empty need no extra flop.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    always_comb begin
        state_d       = state_q;
        dec_tx_d      = dec_tx_q;
        dec_work_d    = 1'b0;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        out_tag_d     = out_tag_q;
        out_data_d    = out_data_q;
        out_timeout_d = out_timeout_q;
        out_valid_d   = out_valid_q;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty && dec_free) begin
                    state_d    = ISSUE;
                    dec_tx_d   = mem_q[rd_ptr_q[AW-1:0]];
                    dec_work_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d   = WAIT;
                cnt_d     = '0;
                out_tag_d = tag_q;
            end
            WAIT: begin
                // A decoder result arriving on the watchdog's last cycle still counts as decoded.
                if (dec_valid) begin
                    state_d       = HOLD;
                    out_data_d    = dec_deout;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    pop           = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d       = HOLD;
                    out_data_d    = dec_tx_q;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    pop           = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    tag_d       = tag_q + TAG_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
        end
        err_d  = err_q || (dec_valid && (state_q != WAIT));
        busy_d = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dec_tx_q      <= '0;
            dec_work_q    <= 1'b0;
            cnt_q         <= '0;
            tag_q         <= '0;
            out_tag_q     <= '0;
            out_data_q    <= '0;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            dec_tx_q      <= dec_tx_d;
            dec_work_q    <= dec_work_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            out_tag_q     <= out_tag_d;
            out_data_q    <= out_data_d;
            out_timeout_q <= out_timeout_d;
            out_valid_q   <= out_valid_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign dec_work     = dec_work_q;
    assign dec_tx       = dec_tx_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_tag      = out_tag_q;
    assign out_timeout  = out_timeout_q;
    assign err_spurious = err_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_osmlgd_frame_sched.sv
// Directed bench for osmlgd_frame_sched: decoder stub, cycle-level reference model with an
// expected-result queue, and literal checks on latency, tags, timeout and reset behaviour.
module tb_osmlgd_frame_sched;

    localparam int W       = 256;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 8;
    localparam int TIMEOUT = 16;
    localparam logic [W-1:0] KEY = {8{32'hA5C3_0F96}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             dec_work;
    logic [W-1:0]     dec_tx;
    logic             dec_free;
    logic [W-1:0]     dec_deout;
    logic             dec_valid;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_timeout;
    logic             err_spurious;
    logic             busy;
    logic [1:0]       dbg_state;

    osmlgd_frame_sched #(
        .W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dec_work(dec_work), .dec_tx(dec_tx), .dec_free(dec_free),
        .dec_deout(dec_deout), .dec_valid(dec_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_timeout(out_timeout),
        .err_spurious(err_spurious), .busy(busy), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int i);
        logic [W-1:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = 32'(i * 8 + k) * 32'h9E37_79B9 ^ 32'hC0DE_0000;
        end
        return r;
    endfunction

    // ---------------- decoder stub ----------------
    // Per frame mode: D>0 raises valid D edges after the work pulse is seen; -1 never answers.
    int  mode_q[$];
    int  stub_cnt   = -1;
    int  stub_delay = 0;
    int  stub_works = 0;
    int  spur_req   = 0;
    int  spur_done  = 0;
    bit  stub_busy  = 1'b0;
    bit  hold_busy  = 1'b0;

    assign dec_free = !stub_busy && !hold_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_cnt  = -1;
            stub_busy = 1'b0;
            dec_valid = 1'b0;
            dec_deout = '0;
        end else begin
            #1;
            dec_valid = 1'b0;
            if (dec_work) begin
                stub_works++;
                stub_delay = (mode_q.size() > 0) ? mode_q.pop_front() : -1;
                stub_cnt   = 0;
                stub_busy  = 1'b1;
            end else if (stub_cnt >= 0) begin
                stub_cnt++;
                if (stub_delay > 0 && stub_cnt == stub_delay) begin
                    dec_valid = 1'b1;
                    dec_deout = dec_tx ^ KEY;
                    stub_cnt  = -1;
                    stub_busy = 1'b0;
                end else if (stub_delay <= 0 && stub_cnt == 20) begin
                    stub_cnt  = -1;
                    stub_busy = 1'b0;
                end
            end else if (spur_req != spur_done) begin
                dec_valid = 1'b1;
                dec_deout = ~KEY;
                spur_done = spur_req;
            end
        end
    end

    // ---------------- scoreboard (intent per accepted word) ----------------
    logic [W-1:0] exp_q[$];
    int           exp_tag_q[$];
    int           exp_to_q[$];
    int           acc_idx = 0;
    int           blocked = 0;

    // ---------------- input sampling away from the edge ----------------
    logic             s_in_valid, s_free, s_dv, s_ordy, s_out_to;
    logic [W-1:0]     s_in_data, s_deout, s_out_data;
    logic [TAG_W-1:0] s_out_tag;

    always @(negedge clk) begin
        s_in_valid = in_valid;
        s_in_data  = in_data;
        s_free     = dec_free;
        s_dv       = dec_valid;
        s_deout    = dec_deout;
        s_ordy     = out_ready;
        s_out_data = out_data;
        s_out_tag  = out_tag;
        s_out_to   = out_timeout;
    end

    // ---------------- reference model ----------------
    // Tracks queued words, the one frame in flight (edges since its work pulse) and the held result.
    int           m_cnt = 0;
    bit           m_flight = 1'b0;
    int           m_since = 0;
    bit           m_hold = 1'b0;
    logic [W-1:0] m_tx = '0;
    logic [W-1:0] m_out = '0;
    bit           m_to = 1'b0;
    int           m_tag = 0;
    int           m_out_tag = 0;
    bit           m_err = 1'b0;
    bit           m_fin, m_push;
    logic [W-1:0] m_in_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_flight = 1'b0; m_since = 0; m_hold = 1'b0;
            m_tx = '0; m_out = '0; m_to = 1'b0; m_tag = 0; m_out_tag = 0; m_err = 1'b0;
            m_in_q.delete();
        end else begin
            m_fin  = 1'b0;
            m_push = s_in_valid && (m_cnt < DEPTH);
            if (s_dv && !(m_flight && m_since >= 1)) m_err = 1'b1;
            if (m_hold) begin
                if (s_ordy) begin
                    chk_i("sb_nonempty", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("sb_data", s_out_data, exp_q.pop_front());
                        chk_i("sb_tag", int'(s_out_tag), exp_tag_q.pop_front());
                        chk_i("sb_timeout", int'(s_out_to), exp_to_q.pop_front());
                    end
                    m_hold = 1'b0;
                    m_tag  = (m_tag + 1) % 256;
                end
            end else if (m_flight) begin
                if (m_since >= 1 && s_dv) begin
                    m_fin = 1'b1; m_out = s_deout; m_to = 1'b0;
                end else if (m_since >= TIMEOUT) begin
                    m_fin = 1'b1; m_out = m_tx; m_to = 1'b1;
                end else begin
                    m_since++;
                end
            end else if (m_cnt > 0 && s_free) begin
                m_flight = 1'b1;
                m_since  = 0;
                m_tx     = m_in_q[0];
            end
            if (m_fin) begin
                m_flight  = 1'b0;
                m_hold    = 1'b1;
                m_out_tag = m_tag;
                m_cnt--;
                void'(m_in_q.pop_front());
            end
            if (m_push) begin
                m_in_q.push_back(s_in_data);
                m_cnt++;
            end
        end
        #1;
        chk_i("in_ready", int'(in_ready), int'(m_cnt < DEPTH));
        chk_i("dec_work", int'(dec_work), int'(m_flight && m_since == 0));
        chk_i("out_valid", int'(out_valid), int'(m_hold));
        chk_i("busy", int'(busy), int'(m_flight || m_hold || m_cnt > 0));
        chk_i("err_spurious", int'(err_spurious), int'(m_err));
        chk("dec_tx", dec_tx, m_tx);
        chk("out_data", out_data, m_out);
        chk_i("out_timeout", int'(out_timeout), int'(m_to));
        if (m_hold) chk_i("out_tag", int'(out_tag), m_out_tag);
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [W-1:0] d, input int mode);
        int  g = 0;
        bit  dec_ok;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && g < 5000) begin
            @(posedge clk); #1;
            g++;
            blocked++;
        end
        chk_i("push_accept_bound", int'(g < 5000), 1);
        if (g < 5000) begin
            dec_ok = (mode > 0) && (mode <= TIMEOUT);
            mode_q.push_back(mode);
            exp_q.push_back(dec_ok ? (d ^ KEY) : d);
            exp_tag_q.push_back(acc_idx % 256);
            exp_to_q.push_back(dec_ok ? 0 : 1);
            acc_idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((m_cnt != 0 || m_flight || m_hold) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        chk_i("drain_bound", int'(g < 3000), 1);
    endtask

    task automatic run_frame(input logic [W-1:0] d, input int mode, input int exp_lat,
                             input logic [W-1:0] exp_data, input int exp_to, input int exp_tag);
        int g = 0;
        int lat = 0;
        push_word(d, mode);
        while (dec_work !== 1'b1 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk_i("frame_work_seen", int'(g < 200), 1);
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_i("frame_latency", lat, exp_lat);
        chk("frame_data", out_data, exp_data);
        chk_i("frame_timeout", int'(out_timeout), exp_to);
        chk_i("frame_tag", int'(out_tag), exp_tag);
    endtask

    task automatic check_reset_outputs();
        chk_i("rst_in_ready", int'(in_ready), 1);
        chk_i("rst_dec_work", int'(dec_work), 0);
        chk("rst_dec_tx", dec_tx, '0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", out_data, '0);
        chk_i("rst_out_tag", int'(out_tag), 0);
        chk_i("rst_out_timeout", int'(out_timeout), 0);
        chk_i("rst_err", int'(err_spurious), 0);
        chk_i("rst_busy", int'(busy), 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        mode_q.delete();
        exp_q.delete();
        exp_tag_q.delete();
        exp_to_q.delete();
        acc_idx  = 0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int w0;

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk); #1;

        // single frame, decoder answers 12 edges after work
        out_ready = 1'b1;
        run_frame(pat(1), 12, 13, pat(1) ^ KEY, 0, 0);
        drain();

        // six words back to back into a four-deep FIFO
        blocked = 0;
        for (int i = 0; i < 6; i++) push_word(pat(10 + i), 3);
        chk_i("b2b_in_ready_dropped", int'(blocked > 0), 1);
        drain();

        // backpressure: result held for 100 cycles while the FIFO fills
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(pat(20 + i), 2);
        w0 = stub_works;
        repeat (100) @(posedge clk);
        #1;
        chk_i("bp_no_new_work", stub_works - w0, 0);
        chk_i("bp_out_valid", int'(out_valid), 1);
        chk_i("bp_in_ready_full", int'(in_ready), 0);
        chk("bp_out_data", out_data, pat(20) ^ KEY);
        chk_i("bp_out_tag", int'(out_tag), 7);
        out_ready = 1'b1;
        drain();

        // decoder reports not free: nothing may be issued
        hold_busy = 1'b1;
        w0 = stub_works;
        push_word(pat(30), 4);
        repeat (10) @(posedge clk);
        #1;
        chk_i("nofree_no_work", stub_works - w0, 0);
        chk_i("nofree_busy", int'(busy), 1);
        hold_busy = 1'b0;
        drain();

        // watchdog: decoder never answers, then the next frame proceeds
        run_frame(pat(40), -1, 17, pat(40), 1, 13);
        run_frame(pat(41), 5, 6, pat(41) ^ KEY, 0, 14);
        drain();

        // spurious valid in IDLE, then valid exactly on the watchdog's last cycle
        spur_req++;
        repeat (3) @(posedge clk);
        #1;
        chk_i("spur_err_set", int'(err_spurious), 1);
        chk_i("spur_no_output", int'(out_valid), 0);
        run_frame(pat(50), 16, 17, pat(50) ^ KEY, 0, 15);
        drain();
        chk_i("spur_err_sticky", int'(err_spurious), 1);

        // reset while a frame waits and three more are queued
        for (int i = 0; i < 4; i++) push_word(pat(60 + i), -1);
        repeat (3) @(posedge clk);
        #1;
        chk_i("pre_rst_busy", int'(busy), 1);
        do_reset();
        @(posedge clk); #1;
        run_frame(pat(70), 4, 5, pat(70) ^ KEY, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
